// File: rtl/text_slot_scheduler.sv
// text_slot_scheduler: shares one ascii_rom among on-screen character slots, commits slot updates only in vblank
module text_slot_scheduler #(
  parameter int         NUM_SLOTS     = 20,
  parameter int         V_ACTIVE      = 480,
  parameter logic [6:0] DEFAULT_ASCII = 7'h30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_slot,
  input  logic        wr_en,
  input  logic [6:0]  wr_ascii,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  output logic [10:0] rom_addr,
  output logic        hit_d,
  output logic [2:0]  col_d,
  output logic        wr_err
);
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  logic       en  [NUM_SLOTS];
  logic [9:0] sx  [NUM_SLOTS];
  logic [9:0] sy  [NUM_SLOTS];
  logic [6:0] asc [NUM_SLOTS];
  state_t     state, state_n;
  logic       vb, hit, hit_1, p_ok, p_en;
  logic [6:0] w_asc, p_ascii;
  logic [3:0] w_row;
  logic [2:0] w_col, col_1;
  logic [4:0] p_slot;
  logic [9:0] p_x, p_y;
  assign vb       = {1'b0, y} >= VA;
  assign p_ok     = {1'b0, p_slot} < 6'(NUM_SLOTS);
  assign wr_ready = state == IDLE;
  assign wr_err   = state == COMMIT && !p_ok;
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit   = 1'b0;
    w_asc = DEFAULT_ASCII;
    w_row = '0;
    w_col = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!vb && en[i] && {1'b0, x} >= {1'b0, sx[i]} && {1'b0, x} < {1'b0, sx[i]} + 11'd8 &&
          {1'b0, y} >= {1'b0, sy[i]} && {1'b0, y} < {1'b0, sy[i]} + 11'd16) begin
        hit   = 1'b1;
        w_asc = asc[i];
        w_row = 4'(y - sy[i]);
        w_col = 3'(x - sx[i]);
      end
  end
  always_comb begin
    state_n = state == IDLE    ? (wr_valid ? PENDING : IDLE) :
              state == PENDING ? (vb ? COMMIT : PENDING) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= {DEFAULT_ASCII, 4'h0};
      hit_1    <= 1'b0;
      col_1    <= '0;
      hit_d    <= 1'b0;
      col_d    <= '0;
    end else begin
      state    <= state_n;
      rom_addr <= {w_asc, w_row};
      hit_1    <= hit;
      col_1    <= w_col;
      hit_d    <= hit_1;
      col_d    <= col_1;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_valid) begin
      p_slot  <= wr_slot;
      p_en    <= wr_en;
      p_ascii <= wr_ascii;
      p_x     <= wr_x;
      p_y     <= wr_y;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        en[i]  <= 1'b0;
        sx[i]  <= '0;
        sy[i]  <= '0;
        asc[i] <= DEFAULT_ASCII;
      end
    end else if (state == COMMIT && p_ok) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (5'(i) == p_slot) begin
          en[i]  <= p_en;
          sx[i]  <= p_x;
          sy[i]  <= p_y;
          asc[i] <= p_ascii;
        end
    end
  end
endmodule

// File: tb/tb_text_slot_scheduler.sv
// tb_text_slot_scheduler: directed stimulus with queued expectations checked by a pipeline-aligned monitor
module tb_text_slot_scheduler;
  logic        clk = 1'b0, reset = 1'b1;
  logic [9:0]  x = '0, y = '0, wr_x = '0, wr_y = '0;
  logic        wr_valid = 1'b0, wr_en = 1'b0;
  logic [4:0]  wr_slot = '0;
  logic [6:0]  wr_ascii = '0;
  logic        wr_ready, hit_d, wr_err;
  logic [10:0] rom_addr;
  logic [2:0]  col_d;
  int          checks = 0, errors = 0, exp_err = 0;
  logic [10:0] q_rom[$];
  logic [3:0]  q_hc[$];
  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

  text_slot_scheduler dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_en(wr_en),
    .wr_ascii(wr_ascii), .wr_x(wr_x), .wr_y(wr_y),
    .rom_addr(rom_addr), .hit_d(hit_d), .col_d(col_d), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Probe tags ride a 2-deep shift so the monitor knows when rom_addr and hit/col belong to a probe.
  always @(posedge clk) begin
    v1 <= v0;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (v1) begin
      if (q_rom.size() == 0) chk("rom_queue_underflow", 1, 0);
      else chk("rom_addr", rom_addr, q_rom.pop_front());
    end
    if (v2) begin
      if (q_hc.size() == 0) chk("hit_queue_underflow", 1, 0);
      else chk("hit_col", {hit_d, col_d}, q_hc.pop_front());
    end
    if (wr_err) begin
      chk("wr_err_expected", exp_err > 0, 1);
      if (exp_err > 0) exp_err--;
    end
  end

  task automatic idle(input logic [9:0] xi, input logic [9:0] yi);
    x = xi; y = yi; v0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input logic [9:0] xi, input logic [9:0] yi, input logic [6:0] a,
                       input logic [3:0] r, input logic h, input logic [2:0] c);
    x = xi; y = yi; v0 = 1'b1;
    q_rom.push_back({a, r});
    q_hc.push_back({h, c});
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic wr(input logic [4:0] s, input logic e, input logic [6:0] a,
                    input logic [9:0] wx, input logic [9:0] wy);
    chk("wr_ready_before_write", wr_ready, 1);
    wr_slot = s; wr_en = e; wr_ascii = a; wr_x = wx; wr_y = wy; wr_valid = 1'b1; v0 = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_ready_pending", wr_ready, 0);
  endtask

  task automatic wait_idle(input logic [9:0] yy);
    int n = 0;
    y = yy; v0 = 1'b0;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("commit_timeout", wr_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_rom_addr", rom_addr, {7'h30, 4'h0});
    chk("reset_hit_d", hit_d, 0);
    chk("reset_col_d", col_d, 0);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_wr_err", wr_err, 0);
    // empty table: nothing hits anywhere in the frame
    for (int yy = 0; yy < 525; yy += 25)
      for (int xx = 0; xx < 800; xx += 45)
        probe(10'(xx), 10'(yy), 7'h30, 4'd0, 1'b0, 3'd0);
    // vblank write lands two cycles after acceptance
    idle(0, 480);
    wr(0, 1'b1, 7'h53, 80, 80);
    idle(0, 480);
    chk("commit_cycle_not_ready", wr_ready, 0);
    idle(0, 480);
    chk("ready_after_commit", wr_ready, 1);
    probe(83, 85, 7'h53, 4'd5, 1'b1, 3'd3);
    probe(88, 85, 7'h30, 4'd0, 1'b0, 3'd0);
    probe(80, 80, 7'h53, 4'd0, 1'b1, 3'd0);
    probe(87, 95, 7'h53, 4'd15, 1'b1, 3'd7);
    probe(87, 96, 7'h30, 4'd0, 1'b0, 3'd0);
    probe(79, 85, 7'h30, 4'd0, 1'b0, 3'd0);
    // active-video write stays pending until vblank, commit cycle sits on y wrapping to 0
    idle(0, 100);
    wr(0, 1'b1, 7'h54, 80, 80);
    for (int i = 0; i < 5; i++) begin
      probe(83, 85, 7'h53, 4'd5, 1'b1, 3'd3);
      chk("wr_ready_held_active", wr_ready, 0);
    end
    idle(0, 480);
    chk("commit_state_not_ready", wr_ready, 0);
    idle(0, 0);
    chk("ready_after_wrap_commit", wr_ready, 1);
    probe(83, 85, 7'h54, 4'd5, 1'b1, 3'd3);
    // overlap priority and vblank clipping
    idle(0, 480);
    wr(3, 1'b1, 7'h31, 120, 140);
    wait_idle(480);
    wr(7, 1'b1, 7'h32, 120, 140);
    wait_idle(480);
    wr(2, 1'b1, 7'h41, 300, 470);
    wait_idle(480);
    probe(121, 141, 7'h31, 4'd1, 1'b1, 3'd1);
    probe(300, 479, 7'h41, 4'd9, 1'b1, 3'd0);
    probe(300, 480, 7'h30, 4'd0, 1'b0, 3'd0);
    idle(0, 480);
    wr(3, 1'b0, 7'h31, 120, 140);
    wait_idle(480);
    probe(121, 141, 7'h32, 4'd1, 1'b1, 3'd1);
    // out-of-range slot: error pulse, table untouched
    idle(0, 480);
    wr(25, 1'b1, 7'h42, 0, 0);
    exp_err++;
    wait_idle(480);
    probe(2, 2, 7'h30, 4'd0, 1'b0, 3'd0);
    probe(121, 141, 7'h32, 4'd1, 1'b1, 3'd1);
    probe(83, 85, 7'h54, 4'd5, 1'b1, 3'd3);
    idle(0, 480);
    idle(0, 480);
    chk("wr_err_pulse_seen", exp_err, 0);
    // reset while pending drops the write and clears the table
    idle(0, 100);
    wr(1, 1'b1, 7'h41, 200, 200);
    idle(0, 100);
    idle(0, 100);
    reset = 1'b1;
    idle(0, 100);
    reset = 1'b0;
    chk("ready_after_reset", wr_ready, 1);
    chk("rom_addr_after_reset", rom_addr, {7'h30, 4'h0});
    repeat (4) idle(0, 480);
    chk("still_idle_no_commit", wr_ready, 1);
    probe(201, 201, 7'h30, 4'd0, 1'b0, 3'd0);
    probe(83, 85, 7'h30, 4'd0, 1'b0, 3'd0);
    probe(121, 141, 7'h30, 4'd0, 1'b0, 3'd0);
    repeat (3) idle(0, 480);
    chk("rom_queue_drained", q_rom.size(), 0);
    chk("hit_queue_drained", q_hc.size(), 0);
    chk("no_missing_wr_err", exp_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
